// File: rtl/aurora_lane_recovery_ctrl.sv
// Per-lane block-lock supervisor: checks sync headers, sequences gearbox slips
// to find alignment, escalates to a lane reset, and tracks drops and outage length.
module aurora_lane_recovery_ctrl #(
    parameter int LOCK_CNT   = 64,
    parameter int ERR_WINDOW = 1024,
    parameter int ERR_THRESH = 16,
    parameter int SLIP_WAIT  = 32,
    parameter int MAX_SLIPS  = 66,
    parameter int RST_CYCLES = 16
) (
    input  logic        clk_rx_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic        rx_valid_i,
    input  logic [1:0]  rx_header_i,
    output logic        lane_rst_o,
    output logic        gbox_slip_o,
    output logic        locked_o,
    output logic [15:0] drop_cnt_o,
    output logic [15:0] last_outage_o,
    output logic [2:0]  state_o
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LRST   = 3'd1;
    localparam logic [2:0] HUNT   = 3'd2;
    localparam logic [2:0] SLIPW  = 3'd3;
    localparam logic [2:0] LOCKED = 3'd4;

    localparam int RW = $clog2(RST_CYCLES) + 1;
    localparam int WW = $clog2(SLIP_WAIT) + 1;
    localparam int GW = $clog2(LOCK_CNT) + 1;
    localparam int MW = $clog2(MAX_SLIPS) + 1;
    localparam int BW = $clog2(ERR_WINDOW) + 1;
    localparam int EW = $clog2(ERR_THRESH) + 1;

    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [MW-1:0] SLIP_LAST = MW'(MAX_SLIPS - 1);
    localparam logic [BW-1:0] BLK_LAST  = BW'(ERR_WINDOW - 1);
    localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_THRESH - 1);

    logic [2:0]    state_reg, state_next;
    logic [RW-1:0] rst_cnt_reg, rst_cnt_next;
    logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
    logic [GW-1:0] good_cnt_reg, good_cnt_next;
    logic [MW-1:0] slip_cnt_reg, slip_cnt_next;
    logic [BW-1:0] blk_cnt_reg, blk_cnt_next;
    logic [EW-1:0] err_cnt_reg, err_cnt_next;
    logic [15:0]   drop_reg, drop_next;
    logic [15:0]   outage_reg, outage_inc, last_outage_reg;
    logic          outage_run_reg;
    logic          lane_rst_reg, slip_reg, locked_reg, slip_pulse;
    logic          hdr_good, hdr_bad, leaving_lock, entering_lock;

    // 01/10 are legal sync headers; 00/11 mean misalignment.
    assign hdr_good = rx_valid_i & (rx_header_i[1] ^ rx_header_i[0]);
    assign hdr_bad  = rx_valid_i & ~(rx_header_i[1] ^ rx_header_i[0]);

    always_comb begin
        state_next    = state_reg;
        rst_cnt_next  = rst_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        good_cnt_next = good_cnt_reg;
        slip_cnt_next = slip_cnt_reg;
        blk_cnt_next  = blk_cnt_reg;
        err_cnt_next  = err_cnt_reg;
        drop_next     = drop_reg;
        slip_pulse    = 1'b0;
        if (!enable_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next    = LRST;
                    rst_cnt_next  = '0;
                    good_cnt_next = '0;
                    slip_cnt_next = '0;
                end
                LRST: begin
                    good_cnt_next = '0;
                    slip_cnt_next = '0;
                    if (rst_cnt_reg == RST_LAST) state_next = HUNT;
                    else rst_cnt_next = rst_cnt_reg + 1'b1;
                end
                HUNT: begin
                    // A bad header outranks a lock-completing good one.
                    if (hdr_bad) begin
                        good_cnt_next = '0;
                        if (slip_cnt_reg == SLIP_LAST) begin
                            state_next   = LRST;
                            rst_cnt_next = '0;
                        end else begin
                            slip_pulse    = 1'b1;
                            slip_cnt_next = slip_cnt_reg + 1'b1;
                            wait_cnt_next = '0;
                            state_next    = SLIPW;
                        end
                    end else if (hdr_good) begin
                        if (good_cnt_reg == GOOD_LAST) begin
                            state_next    = LOCKED;
                            good_cnt_next = '0;
                            blk_cnt_next  = '0;
                            err_cnt_next  = '0;
                        end else begin
                            good_cnt_next = good_cnt_reg + 1'b1;
                        end
                    end
                end
                SLIPW: begin
                    if (wait_cnt_reg == WAIT_LAST) state_next = HUNT;
                    else wait_cnt_next = wait_cnt_reg + 1'b1;
                end
                LOCKED: begin
                    if (rx_valid_i) begin
                        if (hdr_bad && err_cnt_reg == ERR_LAST) begin
                            state_next    = HUNT;
                            drop_next     = (drop_reg == 16'hFFFF) ? drop_reg : drop_reg + 16'd1;
                            slip_cnt_next = '0;
                            good_cnt_next = '0;
                            blk_cnt_next  = '0;
                            err_cnt_next  = '0;
                        end else if (blk_cnt_reg == BLK_LAST) begin
                            blk_cnt_next = '0;
                            err_cnt_next = '0;
                        end else begin
                            blk_cnt_next = blk_cnt_reg + 1'b1;
                            err_cnt_next = err_cnt_reg + {{(EW-1){1'b0}}, hdr_bad};
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign leaving_lock  = (state_reg == LOCKED) && (state_next != LOCKED);
    assign entering_lock = (state_reg != LOCKED) && (state_next == LOCKED);
    assign outage_inc    = (outage_reg == 16'hFFFF) ? outage_reg : outage_reg + 16'd1;

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg       <= IDLE;
            rst_cnt_reg     <= '0;
            wait_cnt_reg    <= '0;
            good_cnt_reg    <= '0;
            slip_cnt_reg    <= '0;
            blk_cnt_reg     <= '0;
            err_cnt_reg     <= '0;
            drop_reg        <= '0;
            outage_reg      <= '0;
            outage_run_reg  <= 1'b0;
            last_outage_reg <= '0;
            lane_rst_reg    <= 1'b0;
            slip_reg        <= 1'b0;
            locked_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rst_cnt_reg  <= rst_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            good_cnt_reg <= good_cnt_next;
            slip_cnt_reg <= slip_cnt_next;
            blk_cnt_reg  <= blk_cnt_next;
            err_cnt_reg  <= err_cnt_next;
            drop_reg     <= drop_next;
            lane_rst_reg <= (state_next == LRST);
            slip_reg     <= slip_pulse;
            locked_reg   <= (state_next == LOCKED);
            // Timer restarts on any exit from lock; the first lock after reset has no outage.
            if (leaving_lock) begin
                outage_reg     <= '0;
                outage_run_reg <= 1'b1;
            end else begin
                outage_reg <= outage_inc;
            end
            if (entering_lock && outage_run_reg) last_outage_reg <= outage_inc;
        end
    end

    assign lane_rst_o    = lane_rst_reg;
    assign gbox_slip_o   = slip_reg;
    assign locked_o      = locked_reg;
    assign drop_cnt_o    = drop_reg;
    assign last_outage_o = last_outage_reg;
    assign state_o       = state_reg;
endmodule
